// File: rtl/pipe_if_stage.sv
// pipe_if_stage: MIPS fetch stage holding the PC register, the next-PC select,
// the instruction-memory req/ack handshake and the IF/ID pipeline register.
// Optional feature macro: IF_TIMEOUT_EN enables a memory-timeout watchdog
// that drives the sticky fetch_err flag.
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        nostall,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] dpc4,
   output logic [31:0] dinst,
   output logic        dvalid,
   output logic        fetch_err
);

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_redirPc;
   logic        r_redirV;
   logic [31:0] r_holdPc4;
   logic [31:0] r_holdInst;
   logic [31:0] r_dpc4;
   logic [31:0] r_dinst;
   logic        r_dvalid;
   logic [31:0] w_pc4;
   logic [31:0] w_tgt;
   logic [31:0] w_npc;
   logic        w_take;
   logic        w_ack;

   // An ack only counts while we are actually requesting.
   assign w_ack  = imem_ack && (r_state == ST_REQ);
   assign w_pc4  = r_pc + 32'd4;
   assign w_take = r_dvalid && nostall && (pcsource != 2'b00);

   // Control-transfer target chosen by the ID stage.
   always_comb begin
      w_tgt = w_pc4;
      case (pcsource)
         2'b01:   w_tgt = bpc;
         2'b10:   w_tgt = da;
         2'b11:   w_tgt = jpc;
         default: w_tgt = w_pc4;
      endcase
   end

   // A redirect latched while the delay-slot fetch was stalled wins over everything.
   assign w_npc = r_redirV ? r_redirPc : (w_take ? w_tgt : w_pc4);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_REQ;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: park the fetched word in HOLD when ID cannot take it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_REQ:  if (w_ack && !nostall) w_nextState = ST_HOLD;
         ST_HOLD: if (nostall) w_nextState = ST_REQ;
         default: w_nextState = ST_REQ;
      endcase
   end

   // Outputs: request only in REQ and never during the reset cycle.
   always_comb begin
      imem_req = (r_state == ST_REQ) && !reset;
   end

   assign imem_addr = r_pc;
   assign dpc4      = r_dpc4;
   assign dinst     = r_dinst;
   assign dvalid    = r_dvalid;

   // PC, redirect, hold buffer and IF/ID register updates.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_redirPc  <= 32'd0;
         r_redirV   <= 1'b0;
         r_holdPc4  <= 32'd0;
         r_holdInst <= 32'd0;
         r_dpc4     <= 32'd0;
         r_dinst    <= 32'd0;
         r_dvalid   <= 1'b0;
      end else if (r_state == ST_REQ) begin
         if (w_ack) begin
            if (nostall) begin
               r_dpc4   <= w_pc4;
               r_dinst  <= imem_rdata;
               r_dvalid <= 1'b1;
               r_pc     <= w_npc;
               r_redirV <= 1'b0;
            end else begin
               r_holdPc4  <= w_pc4;
               r_holdInst <= imem_rdata;
            end
         end else if (nostall) begin
            r_dinst  <= 32'd0;
            r_dvalid <= 1'b0;
            if (w_take) begin
               r_redirPc <= w_tgt;
               r_redirV  <= 1'b1;
            end
         end
      end else if (nostall) begin
         r_dpc4   <= r_holdPc4;
         r_dinst  <= r_holdInst;
         r_dvalid <= 1'b1;
         r_pc     <= w_npc;
         r_redirV <= 1'b0;
      end
   end

`ifdef IF_TIMEOUT_EN
   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

   logic [CW-1:0] r_toCount;
   logic          r_fetchErr;

   // Count consecutive unanswered requests; flag sticks until reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_toCount  <= '0;
         r_fetchErr <= 1'b0;
      end else if ((r_state == ST_REQ) && !imem_ack) begin
         if (r_toCount != TO_MAX) r_toCount <= r_toCount + 1'b1;
         if (r_toCount >= TO_MAX - 1'b1) r_fetchErr <= 1'b1;
      end else if (w_ack) begin
         r_toCount <= '0;
      end
   end

   assign fetch_err = r_fetchErr;
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: directed scenarios for the fetch stage with a simple
// memory that returns addr | 0x1000_0000 whenever ack is driven.
module tb_pipe_if_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        nostall = 1'b1;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] bpc = 32'd0;
   logic [31:0] da = 32'd0;
   logic [31:0] jpc = 32'd0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemRdata;
   logic [31:0] dpc4;
   logic [31:0] dinst;
   logic        dvalid;
   logic        fetchErr;

   int nCompared = 0;
   int nMismatched = 0;

`ifdef IF_TIMEOUT_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   // Free-running clock.
   always #5 clock = ~clock;

   // Memory model: data only meaningful with ack.
   assign imemRdata = imemAck ? (imemAddr | 32'h1000_0000) : 32'hDEAD_BEEF;

   pipe_if_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset), .nostall(nostall), .pcsource(pcsource),
      .bpc(bpc), .da(da), .jpc(jpc), .imem_req(imemReq), .imem_addr(imemAddr),
      .imem_ack(imemAck), .imem_rdata(imemRdata), .dpc4(dpc4), .dinst(dinst),
      .dvalid(dvalid), .fetch_err(fetchErr)
   );

   // Drive inputs for the coming edge, then settle just after it.
   task automatic applyStimulus(input logic ackIn, input logic nstIn, input logic [1:0] psIn);
      imemAck  = ackIn;
      nostall  = nstIn;
      pcsource = psIn;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_req: got %h expected 0", imemReq); end
      nCompared++; if (imemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_addr: got %h expected 0", imemAddr); end
      nCompared++; if (dvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_dvalid: got %h expected 0", dvalid); end
      nCompared++; if (dinst !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_dinst: got %h expected 0", dinst); end
      nCompared++; if (dpc4 !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_dpc4: got %h expected 0", dpc4); end
      nCompared++; if (fetchErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_err: got %h expected 0", fetchErr); end
      reset = 1'b0;
      #1;
      nCompared++; if (imemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL rel_req: got %h expected 1", imemReq); end
   endtask

   task automatic test_sequential();
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dpc4 !== 32'h4) begin nMismatched++; $display("[TB] FAIL seq_dpc4_a: got %h expected 4", dpc4); end
      nCompared++; if (dinst !== 32'h1000_0000) begin nMismatched++; $display("[TB] FAIL seq_dinst_a: got %h expected 10000000", dinst); end
      nCompared++; if (dvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_dvalid: got %h expected 1", dvalid); end
      nCompared++; if (imemAddr !== 32'h4) begin nMismatched++; $display("[TB] FAIL seq_addr_a: got %h expected 4", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dpc4 !== 32'h8) begin nMismatched++; $display("[TB] FAIL seq_dpc4_b: got %h expected 8", dpc4); end
      nCompared++; if (dinst !== 32'h1000_0004) begin nMismatched++; $display("[TB] FAIL seq_dinst_b: got %h expected 10000004", dinst); end
      nCompared++; if (imemAddr !== 32'h8) begin nMismatched++; $display("[TB] FAIL seq_addr_b: got %h expected 8", imemAddr); end
   endtask

   task automatic test_stall();
      applyStimulus(1'b1, 1'b0, 2'b00);
      nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_req: got %h expected 0", imemReq); end
      nCompared++; if (dinst !== 32'h1000_0004) begin nMismatched++; $display("[TB] FAIL hold_dinst: got %h expected 10000004", dinst); end
      nCompared++; if (dpc4 !== 32'h8) begin nMismatched++; $display("[TB] FAIL hold_dpc4: got %h expected 8", dpc4); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 2'b00);
         nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_req_%0d: got %h expected 0", i, imemReq); end
         nCompared++; if (dinst !== 32'h1000_0004) begin nMismatched++; $display("[TB] FAIL hold_dinst_%0d: got %h expected 10000004", i, dinst); end
      end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0008) begin nMismatched++; $display("[TB] FAIL unhold_dinst: got %h expected 10000008", dinst); end
      nCompared++; if (dpc4 !== 32'hC) begin nMismatched++; $display("[TB] FAIL unhold_dpc4: got %h expected c", dpc4); end
      nCompared++; if (imemAddr !== 32'hC) begin nMismatched++; $display("[TB] FAIL unhold_addr: got %h expected c", imemAddr); end
      nCompared++; if (imemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL unhold_req: got %h expected 1", imemReq); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_000C) begin nMismatched++; $display("[TB] FAIL once_dinst: got %h expected 1000000c", dinst); end
      nCompared++; if (imemAddr !== 32'h10) begin nMismatched++; $display("[TB] FAIL once_addr: got %h expected 10", imemAddr); end
   endtask

   task automatic test_branch();
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (imemAddr !== 32'h14) begin nMismatched++; $display("[TB] FAIL br_addr_ds: got %h expected 14", imemAddr); end
      bpc = 32'h40;
      applyStimulus(1'b1, 1'b1, 2'b01);
      nCompared++; if (dinst !== 32'h1000_0014) begin nMismatched++; $display("[TB] FAIL br_dinst_ds: got %h expected 10000014", dinst); end
      nCompared++; if (dpc4 !== 32'h18) begin nMismatched++; $display("[TB] FAIL br_dpc4_ds: got %h expected 18", dpc4); end
      nCompared++; if (imemAddr !== 32'h40) begin nMismatched++; $display("[TB] FAIL br_addr_tgt: got %h expected 40", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0040) begin nMismatched++; $display("[TB] FAIL br_dinst_tgt: got %h expected 10000040", dinst); end
      nCompared++; if (imemAddr !== 32'h44) begin nMismatched++; $display("[TB] FAIL br_addr_44: got %h expected 44", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0044) begin nMismatched++; $display("[TB] FAIL br_dinst_44: got %h expected 10000044", dinst); end
   endtask

   task automatic test_branch_slow();
      applyStimulus(1'b1, 1'b1, 2'b00);
      bpc = 32'h80;
      applyStimulus(1'b0, 1'b1, 2'b01);
      nCompared++; if (dvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL slow_dvalid: got %h expected 0", dvalid); end
      nCompared++; if (dinst !== 32'h0) begin nMismatched++; $display("[TB] FAIL slow_dinst: got %h expected 0", dinst); end
      nCompared++; if (dpc4 !== 32'h4C) begin nMismatched++; $display("[TB] FAIL slow_dpc4: got %h expected 4c", dpc4); end
      nCompared++; if (imemAddr !== 32'h4C) begin nMismatched++; $display("[TB] FAIL slow_addr: got %h expected 4c", imemAddr); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b00);
         nCompared++; if (imemAddr !== 32'h4C) begin nMismatched++; $display("[TB] FAIL slow_addr_%0d: got %h expected 4c", i, imemAddr); end
         nCompared++; if (dvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL slow_dvalid_%0d: got %h expected 0", i, dvalid); end
      end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_004C) begin nMismatched++; $display("[TB] FAIL slow_dinst_ds: got %h expected 1000004c", dinst); end
      nCompared++; if (dvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL slow_dvalid_ds: got %h expected 1", dvalid); end
      nCompared++; if (imemAddr !== 32'h80) begin nMismatched++; $display("[TB] FAIL slow_addr_tgt: got %h expected 80", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0080) begin nMismatched++; $display("[TB] FAIL slow_dinst_tgt: got %h expected 10000080", dinst); end
      // jr variant, with a decoy branch target that must be ignored
      applyStimulus(1'b1, 1'b1, 2'b00);
      da  = 32'h100;
      bpc = 32'h200;
      applyStimulus(1'b0, 1'b1, 2'b10);
      nCompared++; if (imemAddr !== 32'h88) begin nMismatched++; $display("[TB] FAIL jr_addr_wait: got %h expected 88", imemAddr); end
      applyStimulus(1'b0, 1'b1, 2'b00);
      applyStimulus(1'b0, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0088) begin nMismatched++; $display("[TB] FAIL jr_dinst_ds: got %h expected 10000088", dinst); end
      nCompared++; if (imemAddr !== 32'h100) begin nMismatched++; $display("[TB] FAIL jr_addr_tgt: got %h expected 100", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h1000_0100) begin nMismatched++; $display("[TB] FAIL jr_dinst_tgt: got %h expected 10000100", dinst); end
      // jump with fast memory, then a jump to the top of the address space
      jpc = 32'h200;
      applyStimulus(1'b1, 1'b1, 2'b11);
      nCompared++; if (imemAddr !== 32'h200) begin nMismatched++; $display("[TB] FAIL j_addr: got %h expected 200", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      jpc = 32'hFFFF_FFFC;
      applyStimulus(1'b1, 1'b1, 2'b11);
      nCompared++; if (imemAddr !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_addr_top: got %h expected fffffffc", imemAddr); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dpc4 !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_dpc4: got %h expected 0", dpc4); end
      nCompared++; if (imemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_addr: got %h expected 0", imemAddr); end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1'b1, 1'b1, 2'b00);
      bpc = 32'h300;
      applyStimulus(1'b0, 1'b1, 2'b01);
      nCompared++; if (imemAddr !== 32'h4) begin nMismatched++; $display("[TB] FAIL mid_addr_wait: got %h expected 4", imemAddr); end
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_req: got %h expected 0", imemReq); end
      nCompared++; if (imemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_addr_rst: got %h expected 0", imemAddr); end
      nCompared++; if (dvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_dvalid: got %h expected 0", dvalid); end
      reset = 1'b0;
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (imemAddr !== 32'h4) begin nMismatched++; $display("[TB] FAIL mid_redir_clr: got %h expected 4", imemAddr); end
      nCompared++; if (dinst !== 32'h1000_0000) begin nMismatched++; $display("[TB] FAIL mid_dinst: got %h expected 10000000", dinst); end
      applyStimulus(1'b1, 1'b0, 2'b00);
      nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_hold_req: got %h expected 0", imemReq); end
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dinst !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_hold_dinst: got %h expected 0", dinst); end
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'b00);
      nCompared++; if (dvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_hold_stale: got %h expected 0", dvalid); end
      nCompared++; if (imemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_hold_req2: got %h expected 1", imemReq); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (dpc4 !== 32'h4) begin nMismatched++; $display("[TB] FAIL mid_restart: got %h expected 4", dpc4); end
   endtask

   task automatic test_timeout();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 2'b00);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 2'b00);
      nCompared++; if (fetchErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_early: got %h expected 0", fetchErr); end
      nCompared++; if (imemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL to_addr: got %h expected 0", imemAddr); end
      applyStimulus(1'b0, 1'b1, 2'b00);
      nCompared++; if (fetchErr !== ERR_EXP) begin nMismatched++; $display("[TB] FAIL to_set: got %h expected %h", fetchErr, ERR_EXP); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (fetchErr !== ERR_EXP) begin nMismatched++; $display("[TB] FAIL to_sticky: got %h expected %h", fetchErr, ERR_EXP); end
      nCompared++; if (dinst !== 32'h1000_0000) begin nMismatched++; $display("[TB] FAIL to_dinst: got %h expected 10000000", dinst); end
      applyStimulus(1'b1, 1'b1, 2'b00);
      nCompared++; if (fetchErr !== ERR_EXP) begin nMismatched++; $display("[TB] FAIL to_sticky2: got %h expected %h", fetchErr, ERR_EXP); end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_branch_slow();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Runaway guard.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
